// File: rtl/ex_mem_pkg.sv
// Shared decode header for the EX stage: instruction-class bit indices,
// MDU defaults and the EX/MEM register layout.
package ex_mem_pkg;

  localparam int CLS_ADDU  = 0;
  localparam int CLS_SUBU  = 1;
  localparam int CLS_AND   = 2;
  localparam int CLS_OR    = 3;
  localparam int CLS_SLT   = 4;
  localparam int CLS_SLTU  = 5;
  localparam int CLS_ORI   = 6;
  localparam int CLS_LUI   = 7;
  localparam int CLS_ADDIU = 8;
  localparam int CLS_SLL   = 9;
  localparam int CLS_SRL   = 10;
  localparam int CLS_SRA   = 11;
  localparam int CLS_LW    = 12;
  localparam int CLS_SW    = 13;
  localparam int CLS_BEQ   = 14;
  localparam int CLS_JAL   = 15;
  localparam int CLS_JR    = 16;
  localparam int CLS_MFHI  = 17;
  localparam int CLS_MFLO  = 18;
  localparam int CLS_MTHI  = 19;
  localparam int CLS_MTLO  = 20;
  localparam int CLS_MULT  = 21;
  localparam int CLS_MULTU = 22;
  localparam int CLS_DIV   = 23;
  localparam int CLS_DIVU  = 24;

  localparam int unsigned Bitwidth = 25;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } md_op_e;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_e;

  typedef struct packed {
    logic [Bitwidth-1:0] onehot;
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [4:0]          a2;
    logic [4:0]          a3;
    logic                rfwr;
    logic [2:0]          tnew;
    logic [31:0]         aluout;
    logic [31:0]         rd2;
    logic [31:0]         wd;
  } ex_mem_regs_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_mem_mdu.sv
// Multi-cycle multiply/divide unit: result is computed at start, held in
// shadow registers, and committed to HI/LO when the busy counter expires.
module ex_mem_mdu
  import ex_mem_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic        sh_dz_q, sh_dz_d;

  logic        is_md, start, dz;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign is_md  = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign start  = is_md && (state_q == MDU_IDLE);
  assign dz     = (b == '0);
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Division by zero leaves the quotient/remainder as don't-care zeros;
  // the dz flag suppresses their commit.
  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (!dz) begin
      quo_s = $signed(a) / $signed(b);
      rem_s = $signed(a) % $signed(b);
      quo_u = a / b;
      rem_u = a % b;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_dz_d = sh_dz_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_BUSY;
          sh_dz_d = 1'b0;
          cnt_d   = (op == MD_MULT || op == MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          case (op)
            MD_MULT:  {sh_hi_d, sh_lo_d} = prod_s;
            MD_MULTU: {sh_hi_d, sh_lo_d} = prod_u;
            MD_DIV: begin
              sh_hi_d = rem_s;
              sh_lo_d = quo_s;
              sh_dz_d = dz;
            end
            MD_DIVU: begin
              sh_hi_d = rem_u;
              sh_lo_d = quo_u;
              sh_dz_d = dz;
            end
            default: ;
          endcase
        end else if (op == MD_MTHI) begin
          hi_d = a;
        end else if (op == MD_MTLO) begin
          lo_d = a;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
          if (!sh_dz_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_dz_q <= sh_dz_d;
    end
  end

  assign busy = start | (state_q == MDU_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: rtl/ex_mem.sv
// Execute stage with operand forwarding, inline ALU, MDU and the EX/MEM
// pipeline register feeding memory and the decode hazard logic.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Bitwidth-1:0] D_onehot,
  input  logic [31:0]         D_RD1,
  input  logic [31:0]         D_RD2,
  input  logic [4:0]          D_A1,
  input  logic [4:0]          D_A2,
  input  logic [4:0]          D_A3,
  input  logic                D_RFWR,
  input  logic [31:0]         D_pc,
  input  logic [31:0]         D_instr,
  input  logic [2:0]          D_tnew,
  input  logic [4:0]          A3_W,
  input  logic [31:0]         WD_W,
  input  logic                RFWR_W,
  output logic [Bitwidth-1:0] E_onehot,
  output logic [31:0]         E_pc,
  output logic [31:0]         E_instr,
  output logic [4:0]          E_A2,
  output logic [4:0]          E_A3,
  output logic                E_RFWR,
  output logic [2:0]          E_tnew,
  output logic [31:0]         E_ALUout,
  output logic [31:0]         E_RD2,
  output logic [31:0]         E_WD,
  output logic                E_mdu_busy
);

  ex_mem_regs_t e_q, e_d;

  logic [31:0] rs_fwd, rt_fwd, zimm, simm, alu, hi, lo;
  logic [4:0]  shamt;
  md_op_e      md_op;

  // The local E register outranks the W port: it holds the younger write.
  always_comb begin
    if (e_q.a3 == D_A1 && e_q.rfwr && e_q.tnew == '0 && D_A1 != '0) rs_fwd = e_q.wd;
    else if (A3_W == D_A1 && RFWR_W && D_A1 != '0)                  rs_fwd = WD_W;
    else                                                             rs_fwd = D_RD1;
    if (e_q.a3 == D_A2 && e_q.rfwr && e_q.tnew == '0 && D_A2 != '0) rt_fwd = e_q.wd;
    else if (A3_W == D_A2 && RFWR_W && D_A2 != '0)                  rt_fwd = WD_W;
    else                                                             rt_fwd = D_RD2;
  end

  assign zimm  = {16'b0, D_instr[15:0]};
  assign simm  = sext16(D_instr[15:0]);
  assign shamt = D_instr[10:6];

  always_comb begin
    alu = '0;
    if (D_onehot[CLS_ADDU])  alu = rs_fwd + rt_fwd;
    if (D_onehot[CLS_SUBU])  alu = rs_fwd - rt_fwd;
    if (D_onehot[CLS_AND])   alu = rs_fwd & rt_fwd;
    if (D_onehot[CLS_OR])    alu = rs_fwd | rt_fwd;
    if (D_onehot[CLS_SLT])   alu = {31'b0, $signed(rs_fwd) < $signed(rt_fwd)};
    if (D_onehot[CLS_SLTU])  alu = {31'b0, rs_fwd < rt_fwd};
    if (D_onehot[CLS_ORI])   alu = rs_fwd | zimm;
    if (D_onehot[CLS_LUI])   alu = {D_instr[15:0], 16'b0};
    if (D_onehot[CLS_ADDIU] || D_onehot[CLS_LW] || D_onehot[CLS_SW]) alu = rs_fwd + simm;
    if (D_onehot[CLS_SLL])   alu = rt_fwd << shamt;
    if (D_onehot[CLS_SRL])   alu = rt_fwd >> shamt;
    if (D_onehot[CLS_SRA])   alu = $signed(rt_fwd) >>> shamt;
  end

  always_comb begin
    md_op = MD_NONE;
    if (D_onehot[CLS_MULT])       md_op = MD_MULT;
    else if (D_onehot[CLS_MULTU]) md_op = MD_MULTU;
    else if (D_onehot[CLS_DIV])   md_op = MD_DIV;
    else if (D_onehot[CLS_DIVU])  md_op = MD_DIVU;
    else if (D_onehot[CLS_MTHI])  md_op = MD_MTHI;
    else if (D_onehot[CLS_MTLO])  md_op = MD_MTLO;
  end

  ex_mem_mdu #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk  (clk),
    .reset(reset),
    .op   (md_op),
    .a    (rs_fwd),
    .b    (rt_fwd),
    .busy (E_mdu_busy),
    .HI   (hi),
    .LO   (lo)
  );

  always_comb begin
    e_d.onehot = D_onehot;
    e_d.pc     = D_pc;
    e_d.instr  = D_instr;
    e_d.a2     = D_A2;
    e_d.a3     = D_A3;
    e_d.rfwr   = D_RFWR;
    e_d.tnew   = (D_tnew == '0) ? '0 : D_tnew - 3'd1;
    e_d.aluout = alu;
    e_d.rd2    = rt_fwd;
    if (D_onehot[CLS_JAL])       e_d.wd = D_pc + 32'd8;
    else if (D_onehot[CLS_MFHI]) e_d.wd = hi;
    else if (D_onehot[CLS_MFLO]) e_d.wd = lo;
    else                         e_d.wd = alu;
  end

  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  assign E_onehot = e_q.onehot;
  assign E_pc     = e_q.pc;
  assign E_instr  = e_q.instr;
  assign E_A2     = e_q.a2;
  assign E_A3     = e_q.a3;
  assign E_RFWR   = e_q.rfwr;
  assign E_tnew   = e_q.tnew;
  assign E_ALUout = e_q.aluout;
  assign E_RD2    = e_q.rd2;
  assign E_WD     = e_q.wd;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: expectations are queued as each instruction is
// issued and compared once the EX/MEM register has captured it.
module tb_ex_mem;
  import ex_mem_pkg::*;

  localparam int S_ALU = 0, S_WD = 1, S_TNEW = 2, S_RFWR = 3, S_A3 = 4, S_RD2 = 5;
  localparam int S_BUSY = 6, S_PC = 7, S_INSTR = 8, S_ONEHOT = 9, S_A2 = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [Bitwidth-1:0] D_onehot;
  logic [31:0]         D_RD1, D_RD2, D_pc, D_instr, WD_W;
  logic [4:0]          D_A1, D_A2, D_A3, A3_W;
  logic                D_RFWR, RFWR_W;
  logic [2:0]          D_tnew;
  logic [Bitwidth-1:0] E_onehot;
  logic [31:0]         E_pc, E_instr, E_ALUout, E_RD2, E_WD;
  logic [4:0]          E_A2, E_A3;
  logic                E_RFWR, E_mdu_busy;
  logic [2:0]          E_tnew;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int          cls;
    logic [31:0] rd1, rd2, instr, alu, wd;
    logic        rfwr, chk_alu, chk_wd;
    string       tag;
  } vec_t;
  vec_t tv[$];

  ex_mem #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .D_onehot(D_onehot), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3), .D_RFWR(D_RFWR), .D_pc(D_pc),
    .D_instr(D_instr), .D_tnew(D_tnew), .A3_W(A3_W), .WD_W(WD_W), .RFWR_W(RFWR_W),
    .E_onehot(E_onehot), .E_pc(E_pc), .E_instr(E_instr), .E_A2(E_A2), .E_A3(E_A3),
    .E_RFWR(E_RFWR), .E_tnew(E_tnew), .E_ALUout(E_ALUout), .E_RD2(E_RD2),
    .E_WD(E_WD), .E_mdu_busy(E_mdu_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_ALU:    return E_ALUout;
      S_WD:     return E_WD;
      S_TNEW:   return {29'b0, E_tnew};
      S_RFWR:   return {31'b0, E_RFWR};
      S_A3:     return {27'b0, E_A3};
      S_A2:     return {27'b0, E_A2};
      S_RD2:    return E_RD2;
      S_BUSY:   return {31'b0, E_mdu_busy};
      S_PC:     return E_pc;
      S_INSTR:  return E_instr;
      S_ONEHOT: return 32'(E_onehot);
      default:  return 'x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic expect_val(input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic issue(input int cls, input logic [4:0] a1, input logic [31:0] rd1,
                       input logic [4:0] a2, input logic [31:0] rd2, input logic [4:0] a3,
                       input logic rfwr, input logic [31:0] instr, input logic [2:0] tnew,
                       input logic [31:0] pc);
    D_onehot = '0;
    if (cls >= 0) D_onehot[cls] = 1'b1;
    D_A1 = a1;  D_RD1 = rd1;
    D_A2 = a2;  D_RD2 = rd2;
    D_A3 = a3;  D_RFWR = rfwr;
    D_instr = instr;  D_tnew = tnew;  D_pc = pc;
  endtask

  task automatic bubble();
    issue(-1, 5'd0, '0, 5'd0, '0, 5'd0, 1'b0, '0, 3'd0, '0);
  endtask

  task automatic expect_zero_regs(input string tag);
    expect_val(S_ALU, '0, {tag, "_alu"});
    expect_val(S_WD, '0, {tag, "_wd"});
    expect_val(S_TNEW, '0, {tag, "_tnew"});
    expect_val(S_RFWR, '0, {tag, "_rfwr"});
    expect_val(S_A3, '0, {tag, "_a3"});
    expect_val(S_RD2, '0, {tag, "_rd2"});
    expect_val(S_PC, '0, {tag, "_pc"});
    expect_val(S_INSTR, '0, {tag, "_instr"});
    expect_val(S_ONEHOT, '0, {tag, "_onehot"});
    expect_val(S_BUSY, '0, {tag, "_busy"});
  endtask

  // Issues one MDU op and counts the cycles E_mdu_busy stays high,
  // including the cycle the op sits in the D registers.
  task automatic mdu_run(input int cls, input logic [31:0] a, input logic [31:0] b,
                         input int exp_n, input string tag);
    int n;
    issue(cls, 5'd4, a, 5'd5, b, 5'd0, 1'b0, '0, 3'd0, '0);
    #1;
    n = E_mdu_busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      bubble();
      #1;
      if (!E_mdu_busy) break;
      n++;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input string tag);
    issue(CLS_MFHI, 5'd0, '0, 5'd0, '0, 5'd3, 1'b1, '0, 3'd1, '0);
    expect_val(S_WD, exp_hi, {tag, "_hi"});
    step();
    issue(CLS_MFLO, 5'd0, '0, 5'd0, '0, 5'd3, 1'b1, '0, 3'd1, '0);
    expect_val(S_WD, exp_lo, {tag, "_lo"});
    step();
  endtask

  initial begin
    reset = 1'b1;
    A3_W = '0;  WD_W = '0;  RFWR_W = 1'b0;
    issue(CLS_ADDU, 5'd1, 32'd3, 5'd2, 32'd4, 5'd6, 1'b1, 32'h1234, 3'd1, 32'h40);
    step();
    expect_zero_regs("reset");
    step();
    reset = 1'b0;

    // addiu $1,$0,9 then addu $3,$1,$2 with stale $1=5: E forwarding
    issue(CLS_ADDIU, 5'd0, '0, 5'd1, '0, 5'd1, 1'b1, 32'h24010009, 3'd1, 32'h100);
    expect_val(S_ALU, 32'd9, "addiu_alu");
    step();
    issue(CLS_ADDU, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b1, 32'h00221821, 3'd1, 32'h104);
    expect_val(S_ALU, 32'd16, "fwd_e_alu");
    expect_val(S_WD, 32'd16, "fwd_e_wd");
    expect_val(S_TNEW, 32'd0, "fwd_e_tnew");
    expect_val(S_RFWR, 32'd1, "fwd_e_rfwr");
    expect_val(S_A3, 32'd3, "fwd_e_a3");
    step();
    A3_W = 5'd3;  WD_W = 32'd4;  RFWR_W = 1'b1;
    issue(CLS_ADDU, 5'd3, 32'd0, 5'd0, '0, 5'd5, 1'b1, '0, 3'd1, 32'h108);
    expect_val(S_ALU, 32'd16, "fwd_e_over_w");
    step();
    A3_W = 5'd0;  WD_W = 32'h55;
    issue(CLS_ADDU, 5'd0, '0, 5'd0, '0, 5'd6, 1'b1, '0, 3'd1, 32'h10C);
    expect_val(S_ALU, 32'd0, "fwd_zero_reg");
    step();
    A3_W = 5'd2;  WD_W = 32'h20;
    issue(CLS_ADDU, 5'd2, 32'd1, 5'd0, '0, 5'd7, 1'b1, '0, 3'd1, 32'h110);
    expect_val(S_ALU, 32'h20, "fwd_w_only");
    step();
    RFWR_W = 1'b0;
    issue(CLS_ADDU, 5'd0, '0, 5'd7, 32'd0, 5'd8, 1'b1, '0, 3'd1, 32'h114);
    expect_val(S_ALU, 32'h20, "fwd_e_rt");
    expect_val(S_RD2, 32'h20, "fwd_e_rt_rd2");
    step();
    issue(CLS_LW, 5'd9, 32'h1000, 5'd10, '0, 5'd10, 1'b1, 32'h8D2AFFFC, 3'd2, 32'h118);
    expect_val(S_ALU, 32'h0FFC, "lw_addr");
    expect_val(S_TNEW, 32'd1, "lw_tnew");
    step();
    issue(CLS_ADDU, 5'd10, 32'h33, 5'd0, '0, 5'd11, 1'b1, '0, 3'd1, 32'h11C);
    expect_val(S_ALU, 32'h33, "no_fwd_tnew1");
    step();

    tv.push_back('{CLS_SUBU,  32'd5,        32'd7,        32'h0,    32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b1, "subu"});
    tv.push_back('{CLS_AND,   32'hF0F0FF00, 32'h0FF0F0F0, 32'h0,    32'h00F0F000, 32'h00F0F000, 1'b1, 1'b1, 1'b1, "and"});
    tv.push_back('{CLS_OR,    32'hF0F0FF00, 32'h0FF0F0F0, 32'h0,    32'hFFF0FFF0, 32'hFFF0FFF0, 1'b1, 1'b1, 1'b1, "or"});
    tv.push_back('{CLS_SLT,   32'hFFFFFFFF, 32'd1,        32'h0,    32'd1,        32'd1,        1'b1, 1'b1, 1'b1, "slt"});
    tv.push_back('{CLS_SLTU,  32'hFFFFFFFF, 32'd1,        32'h0,    32'd0,        32'd0,        1'b1, 1'b1, 1'b1, "sltu"});
    tv.push_back('{CLS_ORI,   32'h12340000, 32'd0,        32'h8001, 32'h12348001, 32'h12348001, 1'b1, 1'b1, 1'b1, "ori"});
    tv.push_back('{CLS_ADDIU, 32'h10,       32'd0,        32'hFFFF, 32'h0000000F, 32'h0000000F, 1'b1, 1'b1, 1'b1, "addiu_neg"});
    tv.push_back('{CLS_LUI,   32'd0,        32'd0,        32'h8001, 32'h80010000, 32'h80010000, 1'b1, 1'b1, 1'b1, "lui"});
    tv.push_back('{CLS_SLL,   32'd0,        32'd1,        32'h07C0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, "sll31"});
    tv.push_back('{CLS_SRL,   32'd0,        32'h80000000, 32'h0100, 32'h08000000, 32'h08000000, 1'b1, 1'b1, 1'b1, "srl"});
    tv.push_back('{CLS_SRA,   32'd0,        32'h80000000, 32'h0100, 32'hF8000000, 32'hF8000000, 1'b1, 1'b1, 1'b1, "sra"});
    tv.push_back('{CLS_SW,    32'h2000,     32'hDEADBEEF, 32'h0010, 32'h00002010, 32'h0,        1'b0, 1'b1, 1'b0, "sw"});
    tv.push_back('{CLS_JAL,   32'd0,        32'd0,        32'h0,    32'h0,        32'h00003008, 1'b1, 1'b0, 1'b1, "jal"});
    foreach (tv[i]) begin
      issue(tv[i].cls, 5'd1, tv[i].rd1, 5'd2, tv[i].rd2, 5'd20, tv[i].rfwr, tv[i].instr, 3'd1, 32'h3000);
      if (tv[i].chk_alu) expect_val(S_ALU, tv[i].alu, {tv[i].tag, "_alu"});
      if (tv[i].chk_wd)  expect_val(S_WD, tv[i].wd, {tv[i].tag, "_wd"});
      expect_val(S_RD2, tv[i].rd2, {tv[i].tag, "_rd2"});
      expect_val(S_RFWR, {31'b0, tv[i].rfwr}, {tv[i].tag, "_rfwr"});
      step();
    end

    mdu_run(CLS_MULT, 32'hFFFFFFFF, 32'd2, 6, "mult");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    mdu_run(CLS_MULTU, 32'hFFFFFFFF, 32'd2, 6, "multu");
    read_hilo(32'h00000001, 32'hFFFFFFFE, "multu");
    mdu_run(CLS_DIV, 32'hFFFFFFF9, 32'd2, 11, "div");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    mdu_run(CLS_DIVU, 32'd7, 32'd0, 11, "divu_by0");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFD, "divu_by0");
    mdu_run(CLS_DIVU, 32'd7, 32'd2, 11, "divu");
    read_hilo(32'd1, 32'd3, "divu");

    issue(CLS_MTHI, 5'd4, 32'hAAAA5555, 5'd0, '0, 5'd0, 1'b0, '0, 3'd0, '0);
    step();
    issue(CLS_MTLO, 5'd4, 32'h1234ABCD, 5'd0, '0, 5'd0, 1'b0, '0, 3'd0, '0);
    step();
    read_hilo(32'hAAAA5555, 32'h1234ABCD, "mthilo");

    // divu 9/2 interrupted by reset in its third cycle: nothing may commit
    issue(CLS_DIVU, 5'd4, 32'd9, 5'd5, 32'd2, 5'd0, 1'b0, '0, 3'd0, '0);
    step();
    bubble();
    step();
    step();
    reset = 1'b1;
    issue(CLS_ADDU, 5'd1, 32'd3, 5'd2, 32'd4, 5'd6, 1'b1, 32'h1234, 3'd1, 32'h40);
    expect_zero_regs("reset_mid_div");
    step();
    reset = 1'b0;
    bubble();
    for (int i = 0; i < 15; i++) step();
    expect_val(S_BUSY, 32'd0, "post_reset_busy");
    step();
    read_hilo(32'd0, 32'd0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
